// File: rtl/bp_pkg.sv
// Shared decode constants, counter encoding and immediate helpers for the
// dynamic fetch-stage branch predictor.
package bp_pkg;

  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  localparam int unsigned BP_STATIC  = 0;
  localparam int unsigned BP_BIMODAL = 1;
  localparam int unsigned BP_GSHARE  = 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Immediates are produced at instruction width; the top sign-extends to XLEN.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Pattern table of 2-bit saturating counters: one combinational read port and
// one synchronous update port, asynchronously reset to weakly-not-taken.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IdxW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output ctr_t            rd_ctr_o,
  input  logic            upd_valid_i,
  input  logic [IdxW-1:0] upd_idx_i,
  input  logic            upd_taken_i
);

  localparam int unsigned Entries = 1 << IdxW;

  ctr_t tbl_q [Entries];
  ctr_t upd_old;
  ctr_t upd_new;

  // Read returns the registered value, so a same-cycle update is not bypassed.
  assign rd_ctr_o = tbl_q[rd_idx_i];
  assign upd_old  = tbl_q[upd_idx_i];

  always_comb begin
    upd_new = upd_old;
    unique case (upd_old)
      SNT:     upd_new = upd_taken_i ? WNT : SNT;
      WNT:     upd_new = upd_taken_i ? WT  : SNT;
      WT:      upd_new = upd_taken_i ? ST  : WNT;
      ST:      upd_new = upd_taken_i ? ST  : WT;
      default: upd_new = upd_old;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) begin
        tbl_q[i] <= WNT;
      end
    end else if (en_i && upd_valid_i) begin
      tbl_q[upd_idx_i] <= upd_new;
    end
  end

endmodule

// File: rtl/branch_predictor_dyn.sv
// Fetch-stage branch predictor: decodes JAL/branches, predicts with a static,
// bimodal or gshare policy and learns from branches resolved in execute.
module branch_predictor_dyn
  import bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRED_MODE = 1,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned GHR_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      i_instr,
  input  logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      branch_pc,
  output logic                 branch_taken,
  output logic [BHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  output logic [31:0]          o_br_count,
  output logic [31:0]          o_miss_count
);

  localparam bit TableEn = (PRED_MODE != BP_STATIC);
  localparam bit UseGhr  = (PRED_MODE == BP_GSHARE);

  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [BHT_IDX_W-1:0] pc_idx, lookup_idx;
  ctr_t                 rd_ctr;
  logic                 is_jal, is_br;
  logic signed [31:0]   imm_j_s, imm_b_s;
  logic [XLEN-1:0]      tgt_j, tgt_b;
  logic [31:0]          br_cnt_q, br_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic                 unused_ok;

  assign pc_idx     = pc[BHT_IDX_W+1:2];
  assign lookup_idx = UseGhr ? (pc_idx ^ BHT_IDX_W'(ghr_q)) : pc_idx;

  if (GHR_W > 1) begin : g_ghr_shift
    assign ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
  end else begin : g_ghr_bit
    assign ghr_d = upd_taken;
  end

  // History only advances on resolved branches, never speculatively at fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (UseGhr && upd_valid) begin
      ghr_q <= ghr_d;
    end
  end

  bp_counter_table #(
    .IdxW (BHT_IDX_W)
  ) u_table (
    .clk_i       (clk),
    .rst_i       (reset),
    .en_i        (TableEn),
    .rd_idx_i    (lookup_idx),
    .rd_ctr_o    (rd_ctr),
    .upd_valid_i (upd_valid),
    .upd_idx_i   (upd_idx),
    .upd_taken_i (upd_taken)
  );

  assign is_jal  = (i_instr[6:2] == OPC_JAL);
  assign is_br   = (i_instr[6:2] == OPC_BRANCH);
  assign imm_j_s = signed'(imm_j(i_instr[31:0]));
  assign imm_b_s = signed'(imm_b(i_instr[31:0]));
  assign tgt_j   = pc + XLEN'(imm_j_s);
  assign tgt_b   = pc + XLEN'(imm_b_s);

  always_comb begin
    branch_taken = 1'b0;
    branch_pc    = '0;
    pred_idx     = lookup_idx;
    if (reset) begin
      pred_idx = '0;
    end else if (is_jal) begin
      branch_taken = 1'b1;
      branch_pc    = tgt_j;
    end else if (is_br && (!TableEn || rd_ctr[1])) begin
      branch_taken = 1'b1;
      branch_pc    = tgt_b;
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (upd_mispred) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_br_count   = br_cnt_q;
  assign o_miss_count = miss_cnt_q;

  assign unused_ok = ^{i_instr[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_branch_predictor_dyn.sv
// Directed bench: static, bimodal and gshare instances share stimulus and each
// scenario task checks its own hand-computed expectations.
module tb_branch_predictor_dyn;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispred = 1'b0;

  logic [31:0] s_bpc, b_bpc, g_bpc;
  logic        s_tk, b_tk, g_tk;
  logic [5:0]  s_idx, b_idx, g_idx;
  logic [31:0] s_br, s_miss, b_br, b_miss, g_br, g_miss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_dyn #(.XLEN(32), .PRED_MODE(0), .BHT_IDX_W(6), .GHR_W(6)) u_static (
    .clk(clk), .reset(reset), .i_instr(instr), .pc(pc), .branch_pc(s_bpc),
    .branch_taken(s_tk), .pred_idx(s_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .o_br_count(s_br),
    .o_miss_count(s_miss)
  );

  branch_predictor_dyn #(.XLEN(32), .PRED_MODE(1), .BHT_IDX_W(6), .GHR_W(6)) u_bimodal (
    .clk(clk), .reset(reset), .i_instr(instr), .pc(pc), .branch_pc(b_bpc),
    .branch_taken(b_tk), .pred_idx(b_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .o_br_count(b_br),
    .o_miss_count(b_miss)
  );

  branch_predictor_dyn #(.XLEN(32), .PRED_MODE(2), .BHT_IDX_W(6), .GHR_W(6)) u_gshare (
    .clk(clk), .reset(reset), .i_instr(instr), .pc(pc), .branch_pc(g_bpc),
    .branch_taken(g_tk), .pred_idx(g_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .o_br_count(g_br),
    .o_miss_count(g_miss)
  );

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  // All stimulus changes happen at the falling edge; checks follow 1ns later.
  task automatic apply_reset;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic upd(input logic [5:0] idx, input logic t, input logic m);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = t; upd_mispred = m;
    @(negedge clk);
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc_v, input logic [31:0] instr_v);
    pc = pc_v; instr = instr_v;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    lookup(32'h100, enc_b(13'd16));
    checks++; if (b_tk !== 1'b0) begin errors++; $display("FAIL t1_bim_taken got %0b want 0", b_tk); end
    checks++; if (b_bpc !== 32'h0) begin errors++; $display("FAIL t1_bim_pc got %h want 0", b_bpc); end
    checks++; if (b_idx !== 6'd0) begin errors++; $display("FAIL t1_bim_idx got %0d want 0", b_idx); end
    checks++; if (s_tk !== 1'b1 || s_bpc !== 32'h110) begin
      errors++; $display("FAIL t1_static got tk=%0b pc=%h want tk=1 pc=00000110", s_tk, s_bpc);
    end
    checks++; if (g_tk !== 1'b0) begin errors++; $display("FAIL t1_gsh_taken got %0b want 0", g_tk); end
    checks++; if (b_br !== 32'd0 || b_miss !== 32'd0) begin
      errors++; $display("FAIL t1_counts got %0d/%0d want 0/0", b_br, b_miss);
    end
  endtask

  task automatic test_bimodal_train;
    apply_reset();
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    checks++; if (b_tk !== 1'b1 || b_bpc !== 32'h110) begin
      errors++; $display("FAIL t2_st got tk=%0b pc=%h want tk=1 pc=00000110", b_tk, b_bpc);
    end
    lookup(32'h104, enc_b(13'd16));
    checks++; if (b_tk !== 1'b0 || b_idx !== 6'd1) begin
      errors++; $display("FAIL t2_other_idx got tk=%0b idx=%0d want tk=0 idx=1", b_tk, b_idx);
    end
    lookup(32'h100, enc_b(13'd16));
    upd(6'd0, 1'b0, 1'b1);
    checks++; if (b_tk !== 1'b1) begin errors++; $display("FAIL t2_wt got %0b want 1", b_tk); end
    upd(6'd0, 1'b0, 1'b1);
    checks++; if (b_tk !== 1'b0 || b_bpc !== 32'h0) begin
      errors++; $display("FAIL t2_wnt got tk=%0b pc=%h want tk=0 pc=0", b_tk, b_bpc);
    end
    upd(6'd0, 1'b0, 1'b0);
    checks++; if (b_tk !== 1'b0) begin errors++; $display("FAIL t2_snt got %0b want 0", b_tk); end
    upd(6'd0, 1'b1, 1'b0);
    checks++; if (b_tk !== 1'b0) begin errors++; $display("FAIL t2_snt_floor got %0b want 0", b_tk); end
    checks++; if (b_br !== 32'd6 || b_miss !== 32'd2) begin
      errors++; $display("FAIL t2_counts got %0d/%0d want 6/2", b_br, b_miss);
    end
  endtask

  task automatic test_jal_wrap;
    lookup(32'h0000_0FFC, enc_j(21'h1FFFFC));
    checks++; if (s_tk !== 1'b1 || s_bpc !== 32'h0000_0FF8) begin
      errors++; $display("FAIL t3_jal_static got tk=%0b pc=%h want 1/00000ff8", s_tk, s_bpc);
    end
    checks++; if (b_tk !== 1'b1 || b_bpc !== 32'h0000_0FF8) begin
      errors++; $display("FAIL t3_jal_bim got tk=%0b pc=%h want 1/00000ff8", b_tk, b_bpc);
    end
    checks++; if (g_tk !== 1'b1 || g_bpc !== 32'h0000_0FF8) begin
      errors++; $display("FAIL t3_jal_gsh got tk=%0b pc=%h want 1/00000ff8", g_tk, g_bpc);
    end
    lookup(32'hFFFF_FFFC, enc_j(21'd8));
    checks++; if (b_tk !== 1'b1 || b_bpc !== 32'h0000_0004) begin
      errors++; $display("FAIL t3_jal_wrap got tk=%0b pc=%h want 1/00000004", b_tk, b_bpc);
    end
    lookup(32'h0000_1000, enc_j(21'h0ABCDE));
    checks++; if (b_bpc !== 32'h000A_CCDE) begin
      errors++; $display("FAIL t3_jal_bits got %h want 000accde", b_bpc);
    end
    lookup(32'h0000_2000, enc_b(13'h0A5A));
    checks++; if (s_bpc !== 32'h0000_2A5A) begin
      errors++; $display("FAIL t3_br_bits got %h want 00002a5a", s_bpc);
    end
    lookup(32'h0000_0000, enc_b(13'h1FF0));
    checks++; if (s_bpc !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL t3_br_neg_wrap got %h want fffffff0", s_bpc);
    end
    lookup(32'h0000_0200, 32'h0000_8067);
    checks++; if (s_tk !== 1'b0 || s_bpc !== 32'h0) begin
      errors++; $display("FAIL t3_jalr got tk=%0b pc=%h want 0/0", s_tk, s_bpc);
    end
    lookup(32'h0000_0200, 32'h0010_0093);
    checks++; if (s_tk !== 1'b0 || s_bpc !== 32'h0) begin
      errors++; $display("FAIL t3_addi got tk=%0b pc=%h want 0/0", s_tk, s_bpc);
    end
  endtask

  task automatic test_gshare;
    logic [5:0]  ghr;
    logic [4:0]  tseq;
    logic [4:0]  texp;
    logic [31:0] pcv;
    apply_reset();
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b0, 1'b0);
    lookup(32'h100, enc_b(13'd16));
    checks++; if (g_idx !== 6'd6) begin errors++; $display("FAIL t4_idx got %0d want 6", g_idx); end
    checks++; if (g_tk !== 1'b0) begin errors++; $display("FAIL t4_e6_wnt got %0b want 0", g_tk); end
    checks++; if (b_idx !== 6'd0) begin errors++; $display("FAIL t4_bim_idx got %0d want 0", b_idx); end
    ghr  = 6'b000110;
    tseq = 5'b00111;
    texp = 5'b01111;
    for (int k = 0; k < 5; k++) begin
      upd(6'd6, tseq[k], 1'b0);
      ghr = {ghr[4:0], tseq[k]};
      pcv = {24'd0, ghr ^ 6'd6, 2'b00};
      lookup(pcv, enc_b(13'd16));
      checks++; if (g_idx !== 6'd6 || g_tk !== texp[k]) begin
        errors++;
        $display("FAIL t4_e6_step%0d got idx=%0d tk=%0b want idx=6 tk=%0b", k, g_idx, g_tk, texp[k]);
      end
      if (texp[k]) begin
        checks++; if (g_bpc !== pcv + 32'd16) begin
          errors++; $display("FAIL t4_tgt_step%0d got %h want %h", k, g_bpc, pcv + 32'd16);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    lookup(32'h100, enc_b(13'd16));
    upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mispred = 1'b0;
    #1;
    checks++; if (b_tk !== 1'b0) begin errors++; $display("FAIL t5_wnt_nobypass got %0b want 0", b_tk); end
    @(negedge clk); upd_valid = 1'b0; #1;
    checks++; if (b_tk !== 1'b1) begin errors++; $display("FAIL t5_wt_visible got %0b want 1", b_tk); end
    upd_valid = 1'b1;
    #1;
    checks++; if (b_tk !== 1'b1) begin errors++; $display("FAIL t5_wt_old got %0b want 1", b_tk); end
    @(negedge clk); upd_valid = 1'b0; upd_taken = 1'b0;
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b0, 1'b0);
    checks++; if (b_tk !== 1'b1) begin errors++; $display("FAIL t5_st_sat got %0b want 1", b_tk); end
    upd(6'd0, 1'b0, 1'b0);
    checks++; if (b_tk !== 1'b0) begin errors++; $display("FAIL t5_back_wnt got %0b want 0", b_tk); end
  endtask

  task automatic test_async_reset;
    logic [4:0] mis;
    apply_reset();
    lookup(32'h104, enc_b(13'd16));
    mis = 5'b00101;
    for (int k = 0; k < 5; k++) upd(6'd1, 1'b1, mis[k]);
    #1;
    checks++; if (b_br !== 32'd5 || b_miss !== 32'd2) begin
      errors++; $display("FAIL t6_bim_counts got %0d/%0d want 5/2", b_br, b_miss);
    end
    checks++; if (s_br !== 32'd5 || s_miss !== 32'd2) begin
      errors++; $display("FAIL t6_static_counts got %0d/%0d want 5/2", s_br, s_miss);
    end
    checks++; if (b_tk !== 1'b1 || b_idx !== 6'd1) begin
      errors++; $display("FAIL t6_pre got tk=%0b idx=%0d want 1/1", b_tk, b_idx);
    end
    @(posedge clk); #2; reset = 1'b1; #1;
    checks++; if (b_tk !== 1'b0 || b_bpc !== 32'h0 || b_idx !== 6'd0) begin
      errors++; $display("FAIL t6_async_out got tk=%0b pc=%h idx=%0d want 0/0/0", b_tk, b_bpc, b_idx);
    end
    checks++; if (s_tk !== 1'b0 || s_bpc !== 32'h0) begin
      errors++; $display("FAIL t6_async_static got tk=%0b pc=%h want 0/0", s_tk, s_bpc);
    end
    checks++; if (b_br !== 32'd0 || b_miss !== 32'd0 || s_br !== 32'd0) begin
      errors++; $display("FAIL t6_async_cnt got %0d/%0d/%0d want 0/0/0", b_br, b_miss, s_br);
    end
    upd_valid = 1'b1; upd_idx = 6'd1; upd_taken = 1'b1; upd_mispred = 1'b1;
    @(posedge clk); #2;
    checks++; if (g_br !== 32'd0 || g_miss !== 32'd0) begin
      errors++; $display("FAIL t6_upd_in_reset got %0d/%0d want 0/0", g_br, g_miss);
    end
    @(negedge clk);
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0; reset = 1'b0;
    #1;
    checks++; if (b_tk !== 1'b0 || b_idx !== 6'd1) begin
      errors++; $display("FAIL t6_release got tk=%0b idx=%0d want 0/1", b_tk, b_idx);
    end
    checks++; if (s_tk !== 1'b1 || s_bpc !== 32'h114) begin
      errors++; $display("FAIL t6_release_static got tk=%0b pc=%h want 1/00000114", s_tk, s_bpc);
    end
    @(negedge clk);
    upd(6'd1, 1'b1, 1'b0);
    checks++; if (b_tk !== 1'b1 || b_br !== 32'd1) begin
      errors++; $display("FAIL t6_wnt_to_wt got tk=%0b br=%0d want 1/1", b_tk, b_br);
    end
  endtask

  initial begin
    test_reset();
    test_bimodal_train();
    test_jal_wrap();
    test_gshare();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
